// File: rtl/traffic_pkg.sv
// Shared light encoding and default parameters for the traffic controller
// front end.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF           = 4;

endpackage

// File: rtl/sensor_debounce.sv
// One street's detector path: two-flop synchroniser, debouncer, arrival edge
// detect, pending-request latch and saturating arrival counter.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw,
    input  logic             green,
    output logic             req_out,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned       DC_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DC_W-1:0]   DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic            s1;
    logic            s2;
    logic            deb;
    logic            deb_q;
    logic [DC_W-1:0] dc;
    logic            req;
    logic            arr;

    assign arr = deb & ~deb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            dc    <= '0;
            req   <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;

            // Any return of s2 to the accepted level restarts the stability count.
            if (s2 == deb) begin
                dc <= '0;
            end else if (dc == DC_LAST) begin
                deb <= s2;
                dc  <= '0;
            end else begin
                dc <= dc + DC_W'(1);
            end

            // Green clears even on an arrival cycle: that car is served by this green.
            if (green) begin
                req <= 1'b0;
            end else if (arr) begin
                req <= 1'b1;
            end

            if (green) begin
                cnt <= '0;
            end else if (arr && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A car still on the detector holds the request through its own green.
    assign req_out = deb | req;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the raw street A/B car detectors into light_fsm's sa/sb requests,
// clearing each pending request once that street has been served green.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             la1,
    input  logic             la0,
    input  logic             lb1,
    input  logic             lb0,
    output logic             sa,
    output logic             sb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic green_a;
    logic green_b;

    // Only the exact GREEN code clears; YELLOW, RED and the illegal 2'b11 do not.
    assign green_a = ({la1, la0} == 2'(GREEN));
    assign green_b = ({lb1, lb0} == 2'(GREEN));

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_street_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_a),
        .green  (green_a),
        .req_out(sa),
        .cnt    (cnt_a)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_street_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_b),
        .green  (green_b),
        .req_out(sb),
        .cnt    (cnt_b)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed scenarios plus randomized detector/light traffic, checked every
// cycle against a window-based behavioural model of both streets.
module tb_traffic_sensor_conditioner;

    localparam int D      = 4;
    localparam int CW     = 4;
    localparam int CMAX   = 15;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          raw_a   = 1'b1;
    logic          raw_b   = 1'b1;
    logic [1:0]    light_a = 2'b10;
    logic [1:0]    light_b = 2'b00;
    logic          sa;
    logic          sb;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .raw_a(raw_a),
        .raw_b(raw_b),
        .la1  (light_a[1]),
        .la0  (light_a[0]),
        .lb1  (light_b[1]),
        .lb0  (light_b[0]),
        .sa   (sa),
        .sb   (sb),
        .cnt_a(cnt_a),
        .cnt_b(cnt_b)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: raw is seen two edges late; the debounced level adopts a new value
    // once the last D pre-edge samples all hold it.
    bit m_s1   [2];
    bit m_s2   [2];
    bit m_deb  [2];
    bit m_debq [2];
    bit m_req  [2];
    int m_cnt  [2];
    bit m_hist [2][D];
    int m_fill [2];

    task automatic model_step(input int i, input bit raw, input logic [1:0] light);
        bit green;
        bit arrival;
        bit all_same;
        green   = (light == 2'b00);
        arrival = m_deb[i] && !m_debq[i];
        m_debq[i] = m_deb[i];
        if (green) begin
            m_req[i] = 1'b0;
            m_cnt[i] = 0;
        end else if (arrival) begin
            m_req[i] = 1'b1;
            if (m_cnt[i] < CMAX) m_cnt[i]++;
        end
        for (int k = D - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = m_s2[i];
        if (m_fill[i] < D) m_fill[i]++;
        if (m_fill[i] == D && m_s2[i] != m_deb[i]) begin
            all_same = 1'b1;
            for (int k = 0; k < D; k++) if (m_hist[i][k] != m_s2[i]) all_same = 1'b0;
            if (all_same) m_deb[i] = m_s2[i];
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debq[i] = 0;
                m_req[i] = 0; m_cnt[i] = 0; m_fill[i] = 0;
                for (int k = 0; k < D; k++) m_hist[i][k] = 0;
            end
        end else begin
            model_step(0, raw_a, light_a);
            model_step(1, raw_b, light_b);
        end
    end

    // Per-cycle comparison, well clear of both clock edges and of reset pulses.
    always @(posedge clk) begin
        #20;
        check("sa",    int'(sa),    int'(m_deb[0] | m_req[0]));
        check("sb",    int'(sb),    int'(m_deb[1] | m_req[1]));
        check("cnt_a", int'(cnt_a), m_cnt[0]);
        check("cnt_b", int'(cnt_b), m_cnt[1]);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        #30;
    endtask

    initial begin
        // 1: async reset holds outputs low with raws high and no clock edge yet
        #30;
        check("rst_sa", int'(sa), 0);
        check("rst_sb", int'(sb), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_cnt_b", int'(cnt_b), 0);
        #70 reset = 1'b1;
        after_edges(5);
        check("t1_sa_edge5", int'(sa), 0);
        after_edges(1);
        check("t1_sa_edge6", int'(sa), 1);
        after_edges(1);
        check("t1_cnt_a", int'(cnt_a), 1);
        check("t1_cnt_b_green", int'(cnt_b), 0);

        // 2: a 3-cycle glitch never reaches the debounced level
        step(1);
        raw_a = 1'b0; light_a = 2'b00;
        step(12);
        light_a = 2'b10;
        step(2);
        raw_a = 1'b1;
        step(3);
        raw_a = 1'b0;
        step(20);
        check("t2_sa", int'(sa), 0);
        check("t2_cnt_a", int'(cnt_a), 0);

        // 3: departed car stays latched until A goes green
        raw_a = 1'b1;
        step(8);
        raw_a = 1'b0;
        step(12);
        check("t3_sa_latched", int'(sa), 1);
        check("t3_cnt_a", int'(cnt_a), 1);
        light_a = 2'b00;
        after_edges(1);
        check("t3_sa_cleared", int'(sa), 0);
        check("t3_cnt_cleared", int'(cnt_a), 0);

        // 4: arrival coinciding with green never latches
        step(1);
        light_a = 2'b10;
        step(2);
        raw_a = 1'b1;
        step(5);
        light_a = 2'b00;
        step(4);
        check("t4_sa_held", int'(sa), 1);
        check("t4_cnt_a", int'(cnt_a), 0);
        raw_a = 1'b0;
        step(10);
        check("t4_sa_no_latch", int'(sa), 0);

        // 5: counter saturation on B
        light_a = 2'b10;
        raw_b = 1'b0;
        step(10);
        light_b = 2'b10;
        step(2);
        for (int p = 0; p < 20; p++) begin
            raw_b = 1'b1;
            step(6);
            raw_b = 1'b0;
            step(6);
            if (p == 0) check("t5_cnt_b_first", int'(cnt_b), 1);
        end
        check("t5_cnt_b_sat", int'(cnt_b), CMAX);
        check("t5_sb", int'(sb), 1);

        // 6: reset mid-debounce on both streets
        raw_a = 1'b1; raw_b = 1'b1;
        step(3);
        @(posedge clk);
        #40 reset = 1'b0;
        #5;
        check("t6_sa_rst", int'(sa), 0);
        check("t6_sb_rst", int'(sb), 0);
        check("t6_cnt_b_rst", int'(cnt_b), 0);
        #25 reset = 1'b1;
        after_edges(5);
        check("t6_sa_edge5", int'(sa), 0);
        check("t6_sb_edge5", int'(sb), 0);
        after_edges(1);
        check("t6_sa_edge6", int'(sa), 1);
        check("t6_sb_edge6", int'(sb), 1);

        // 7: random detector activity and light changes, including illegal 2'b11
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) raw_a = ~raw_a;
            if ($urandom_range(0, 5) == 0) raw_b = ~raw_b;
            if ($urandom_range(0, 39) == 0) light_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) light_b = 2'($urandom_range(0, 3));
        end
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
